gray_ptr_rx: RTL and testbench

GRAY_PTR_RX -- requirements
Module: gray_ptr_rx

---
 rtl/gray_ptr_rx.sv | 111 +++++++++++
 tb/tb_gray_ptr_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_rx.sv
// rtl/gray_ptr_rx.sv - receive side of a Gray-coded pointer crossing: sync, decode, occupancy flags
// Optional Gray transition checker enabled by defining GRAY_PTR_RX_ERRCHK_EN.
module gray_ptr_rx #(
  parameter int SIZE        = 5,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] wr_gray,
  input  logic [SIZE-1:0] rd_bin,
  output logic [SIZE-1:0] wr_bin,
  output logic [SIZE-1:0] level,
  output logic            empty,
  output logic            almost_empty,
  output logic            full,
  output logic            gray_err,
  output logic [7:0]      err_cnt
);

  localparam logic [SIZE-1:0] AE_LVL   = SIZE'(AE_THRESH);
  localparam logic [SIZE-1:0] FULL_LVL = {1'b1, {(SIZE-1){1'b0}}};

  logic [SIZE-1:0] r_sync [SYNC_STAGES];
  logic [SIZE-1:0] r_wr_bin;
  logic [SIZE-1:0] r_level;
  logic            r_empty;
  logic            r_almost_empty;
  logic            r_full;

  logic [SIZE-1:0] w_gray_s;
  logic [SIZE-1:0] w_bin_next;
  logic [SIZE-1:0] w_level_next;

  assign w_gray_s = r_sync[SYNC_STAGES-1];

  // Bit i of the binary value is the XOR-reduction of Gray bits i and above.
  always_comb begin
    w_bin_next = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_bin_next[i] = ^(w_gray_s >> i);
    end
  end

  // Modular difference; rd_bin is used as presented, wr_bin as last registered.
  assign w_level_next = r_wr_bin - rd_bin;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
      r_wr_bin       <= '0;
      r_level        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_full         <= 1'b0;
    end else begin
      r_sync[0] <= wr_gray;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_wr_bin       <= w_bin_next;
      r_level        <= w_level_next;
      r_empty        <= (w_level_next == '0);
      r_almost_empty <= (w_level_next <= AE_LVL);
      r_full         <= (w_level_next == FULL_LVL);
    end
  end

  assign wr_bin       = r_wr_bin;
  assign level        = r_level;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign full         = r_full;

`ifdef GRAY_PTR_RX_ERRCHK_EN
  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  logic [SIZE-1:0] r_gray_prev;
  logic            r_gray_err;
  logic [7:0]      r_err_cnt;
  logic [SIZE-1:0] w_gray_diff;
  logic            w_multi_bit;

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign w_gray_diff = w_gray_s ^ r_gray_prev;
  assign w_multi_bit = ((w_gray_diff & (w_gray_diff - ONE)) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gray_prev <= '0;
      r_gray_err  <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_gray_prev <= w_gray_s;
      r_gray_err  <= w_multi_bit;
      if (r_gray_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign gray_err = r_gray_err;
  assign err_cnt  = r_err_cnt;
`else
  assign gray_err = 1'b0;
  assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_gray_ptr_rx.sv
// tb/tb_gray_ptr_rx.sv - directed vector bench for gray_ptr_rx (SIZE=5, SYNC_STAGES=2, AE_THRESH=2)
module tb_gray_ptr_rx;

`ifdef GRAY_PTR_RX_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] wr_gray;
  logic [4:0] rd_bin;
  logic [4:0] wr_bin;
  logic [4:0] level;
  logic       empty;
  logic       almost_empty;
  logic       full;
  logic       gray_err;
  logic [7:0] err_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  gray_ptr_rx #(.SIZE(5), .SYNC_STAGES(2), .AE_THRESH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_gray      (wr_gray),
    .rd_bin       (rd_bin),
    .wr_bin       (wr_bin),
    .level        (level),
    .empty        (empty),
    .almost_empty (almost_empty),
    .full         (full),
    .gray_err     (gray_err),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] g;
    logic [4:0] rd;
    logic [4:0] wb;
    logic [4:0] lvl;
    logic       e;
    logic       ae;
    logic       f;
    logic       ge;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic r, logic [4:0] g, logic [4:0] rd, logic [4:0] wb,
                              logic [4:0] lvl, logic e, logic ae, logic f, logic ge,
                              logic [7:0] cnt);
    vec_t v;
    v.rst = r; v.g = g; v.rd = rd; v.wb = wb; v.lvl = lvl;
    v.e = e; v.ae = ae; v.f = f; v.ge = ge; v.cnt = cnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [4:0] wb, logic [4:0] lvl, logic e, logic ae,
                         logic f, logic ge, logic [7:0] cnt);
    chk({tag, " wr_bin"},       8'(wr_bin),       8'(wb));
    chk({tag, " level"},        8'(level),        8'(lvl));
    chk({tag, " empty"},        8'(empty),        8'(e));
    chk({tag, " almost_empty"}, 8'(almost_empty), 8'(ae));
    chk({tag, " full"},         8'(full),         8'(f));
    chk({tag, " gray_err"},     8'(gray_err),     8'(ge & ERRCHK));
    chk({tag, " err_cnt"},      8'(err_cnt),      ERRCHK ? cnt : 8'd0);
  endtask

  initial begin
    // Reset with 10110 pending, release, watch the 4-edge latency and the single error pulse.
    tbl[0]  = mk(1'b1, 5'h16, 5'h00, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[1]  = mk(1'b1, 5'h16, 5'h00, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[2]  = mk(1'b1, 5'h16, 5'h00, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[3]  = mk(1'b0, 5'h16, 5'h00, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[4]  = mk(1'b0, 5'h16, 5'h00, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[5]  = mk(1'b0, 5'h16, 5'h00, 5'h1B, 5'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
    tbl[6]  = mk(1'b0, 5'h16, 5'h00, 5'h1B, 5'h1B, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    // Mid-operation reset with non-zero inputs.
    tbl[7]  = mk(1'b1, 5'h16, 5'h05, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    // Single step 00000 -> 00001.
    tbl[8]  = mk(1'b0, 5'h01, 5'h00, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[9]  = mk(1'b0, 5'h01, 5'h00, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[10] = mk(1'b0, 5'h01, 5'h00, 5'h01, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[11] = mk(1'b0, 5'h01, 5'h00, 5'h01, 5'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    // rd_bin steps on the same edge wr_bin picks up 1: transient 0-1 = 31, then 0.
    tbl[12] = mk(1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[13] = mk(1'b0, 5'h01, 5'h00, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[14] = mk(1'b0, 5'h01, 5'h00, 5'h00, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tbl[15] = mk(1'b0, 5'h01, 5'h01, 5'h01, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tbl[16] = mk(1'b0, 5'h01, 5'h01, 5'h01, 5'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);

    rst     = 1'b1;
    wr_gray = 5'h00;
    rd_bin  = 5'h00;

    for (int i = 0; i < 17; i++) begin
      rst     = tbl[i].rst;
      wr_gray = tbl[i].g;
      rd_bin  = tbl[i].rd;
      tick();
      chk_all($sformatf("row%0d", i), tbl[i].wb, tbl[i].lvl, tbl[i].e, tbl[i].ae,
              tbl[i].f, tbl[i].ge, tbl[i].cnt);
    end

    // Legal walk up to binary 16 -> full.
    rst = 1'b1; wr_gray = 5'h00; rd_bin = 5'h00;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      logic [4:0] b;
      b = 5'(i);
      wr_gray = b ^ (b >> 1);
      tick();
      chk($sformatf("walk%0d gray_err", i), 8'(gray_err), 8'd0);
    end
    repeat (3) tick();
    chk_all("full", 5'd16, 5'd16, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    // Continue past 31 -> 0 -> 1, then rd_bin = 31 gives a wrapped occupancy of 2.
    for (int i = 17; i <= 33; i++) begin
      logic [4:0] b;
      b = 5'(i % 32);
      wr_gray = b ^ (b >> 1);
      tick();
      chk($sformatf("wrapwalk%0d gray_err", i), 8'(gray_err), 8'd0);
    end
    rd_bin = 5'd31;
    repeat (3) tick();
    chk_all("wrap", 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

    // Illegal jump 00000 -> 00011, then a long run of illegal jumps to saturate the counter.
    rst = 1'b1; wr_gray = 5'h00; rd_bin = 5'h00;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    wr_gray = 5'h03;
    repeat (3) tick();
    chk("jump gray_err",  8'(gray_err), 8'(ERRCHK));
    chk("jump err_cnt",   err_cnt,      8'd0);
    tick();
    chk("after gray_err", 8'(gray_err), 8'd0);
    chk("after err_cnt",  err_cnt,      ERRCHK ? 8'd1 : 8'd0);
    for (int k = 0; k < 300; k++) begin
      wr_gray = (k % 2 == 0) ? 5'h00 : 5'h03;
      tick();
    end
    repeat (4) tick();
    chk("sat gray_err", 8'(gray_err), 8'd0);
    chk("sat err_cnt",  err_cnt,      ERRCHK ? 8'd255 : 8'd0);
    wr_gray = 5'h00;
    repeat (4) tick();
    chk("sat hold err_cnt", err_cnt,  ERRCHK ? 8'd255 : 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
